// File: rtl/base_asmx.sv
// Loop-exit steering block for a dataflow loop.
// Each accepted loop-state beat is either fed back to the loop latch
// (single-cycle f_v pulse) or pushed into a 2-entry in-order exit buffer.
// An iteration counter tracks beats per loop run and saturates at all-ones.
// Optional feature: define BASE_ASMX_ITER_LIMIT_EN to force an exit (o_err=1)
// once an iteration count reaches max_iter.
module base_asmx #(
  parameter int unsigned width     = 1,
  parameter int unsigned cnt_width = 8,
  parameter int unsigned max_iter  = 255
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_v,
  output logic                 i_r,
  input  logic [width-1:0]     i_d,
  input  logic                 i_done,
  output logic                 f_v,
  output logic [width-1:0]     f_d,
  output logic                 o_v,
  input  logic                 o_r,
  output logic [width-1:0]     o_d,
  output logic [cnt_width-1:0] o_cnt,
  output logic                 o_err
);

  localparam logic [cnt_width-1:0] CntMax = '1;

  // Reject an iteration limit that the counter cannot represent.
  if (max_iter == 0 || 64'(max_iter) >= (64'd1 << cnt_width)) begin : g_bad_max_iter
    $error("base_asmx: max_iter must be in 1..2^cnt_width-1");
  end

  // Gates i_r so it rises on the first clock edge after reset release.
  logic                 rdy_q;
  logic [cnt_width-1:0] cnt_q;
  logic                 f_v_q;
  logic [width-1:0]     f_d_q;

  // Exit buffer storage, addressed by 1-bit pointers.
  logic [width-1:0]     data_q [2];
  logic [cnt_width-1:0] cntb_q [2];
  logic                 wr_ptr_q;
  logic                 rd_ptr_q;
  logic [1:0]           count_q;

  logic                 full;
  logic                 accept;
  logic                 exit_beat;
  logic                 cont_beat;
  logic                 push;
  logic                 pop;
  logic [cnt_width-1:0] cnt_inc;

  assign full      = (count_q == 2'd2);
  // Ready depends on state only; a pop in the same cycle does not free a slot.
  assign i_r       = rdy_q & ~full;
  assign accept    = i_v & i_r;
  assign cnt_inc   = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
  assign cont_beat = accept & ~exit_beat;
  assign push      = exit_beat;
  assign o_v       = (count_q != 2'd0);
  assign pop       = o_v & o_r;

  assign f_v   = f_v_q;
  assign f_d   = f_d_q;
  assign o_d   = data_q[rd_ptr_q];
  assign o_cnt = cntb_q[rd_ptr_q];

`ifdef BASE_ASMX_ITER_LIMIT_EN
  localparam logic [cnt_width-1:0] LimitCnt = cnt_width'(max_iter);

  logic forced;
  logic err_q [2];

  // Counter stays below max_iter here, so cnt_inc is an exact increment.
  assign forced    = ~i_done & (cnt_inc == LimitCnt);
  assign exit_beat = accept & (i_done | forced);
  assign o_err     = err_q[rd_ptr_q];

  // Forced-exit flag stored alongside each buffered result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q[0] <= 1'b0;
      err_q[1] <= 1'b0;
    end else if (push) begin
      err_q[wr_ptr_q] <= forced;
    end
  end
`else
  assign exit_beat = accept & i_done;
  assign o_err     = 1'b0;
`endif

  // Loop control state: feedback pulse, iteration counter and exit FIFO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdy_q     <= 1'b0;
      cnt_q     <= '0;
      f_v_q     <= 1'b0;
      f_d_q     <= '0;
      data_q[0] <= '0;
      data_q[1] <= '0;
      cntb_q[0] <= '0;
      cntb_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      rdy_q <= 1'b1;
      f_v_q <= cont_beat;
      if (cont_beat) begin
        f_d_q <= i_d;
      end
      if (exit_beat) begin
        cnt_q <= '0;
      end else if (cont_beat) begin
        cnt_q <= cnt_inc;
      end
      if (push) begin
        data_q[wr_ptr_q] <= i_d;
        cntb_q[wr_ptr_q] <= cnt_inc;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: tb/tb_base_asmx.sv
// Self-checking bench for base_asmx: directed scenarios plus a random run
// checked cycle by cycle against a queue-based behavioural model.
module tb_base_asmx;

  localparam int W    = 8;
  localparam int CW   = 3;
  localparam int MI   = 4;
  localparam int CMAX = (1 << CW) - 1;
`ifdef BASE_ASMX_ITER_LIMIT_EN
  localparam bit LIMIT = 1'b1;
`else
  localparam bit LIMIT = 1'b0;
`endif

  logic          clk;
  logic          reset_n;
  logic          i_v;
  logic          i_r;
  logic [W-1:0]  i_d;
  logic          i_done;
  logic          f_v;
  logic [W-1:0]  f_d;
  logic          o_v;
  logic          o_r;
  logic [W-1:0]  o_d;
  logic [CW-1:0] o_cnt;
  logic          o_err;

  int n_total = 0;
  int n_bad   = 0;

  typedef struct {
    logic [W-1:0] d;
    int           cnt;
    bit           err;
  } ent_t;

  // Behavioural model state.
  ent_t         m_q[$];
  int           m_cnt;
  bit           m_fv;
  logic [W-1:0] m_fd;
  bit           m_rdy;

  base_asmx #(
    .width    (W),
    .cnt_width(CW),
    .max_iter (MI)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .i_v    (i_v),
    .i_r    (i_r),
    .i_d    (i_d),
    .i_done (i_done),
    .f_v    (f_v),
    .f_d    (f_d),
    .o_v    (o_v),
    .o_r    (o_r),
    .o_d    (o_d),
    .o_cnt  (o_cnt),
    .o_err  (o_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_cnt = 0;
    m_fv  = 1'b0;
    m_fd  = '0;
    m_rdy = 1'b0;
  endtask

  // Advance one clock: model follows the rules at the rising edge, then
  // return at the falling edge where outputs are sampled and inputs driven.
  task automatic tick();
    bit   ir;
    bit   acc;
    ent_t e;
    @(posedge clk);
    ir  = m_rdy && (m_q.size() < 2);
    acc = i_v && ir;
    if (o_r && m_q.size() > 0) void'(m_q.pop_front());
    if (acc) begin
      if (i_done) begin
        e = '{d: i_d, cnt: sat(m_cnt + 1), err: 1'b0};
        m_q.push_back(e);
        m_cnt = 0;
        m_fv  = 1'b0;
      end else if (LIMIT && (m_cnt + 1 == MI)) begin
        e = '{d: i_d, cnt: MI, err: 1'b1};
        m_q.push_back(e);
        m_cnt = 0;
        m_fv  = 1'b0;
      end else begin
        m_cnt = sat(m_cnt + 1);
        m_fv  = 1'b1;
        m_fd  = i_d;
      end
    end else begin
      m_fv = 1'b0;
    end
    m_rdy = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    i_v = 1'b0; i_d = '0; i_done = 1'b0; o_r = 1'b0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    model_reset();
    #11;
    n_total++;
    if ({f_v, o_v, i_r, o_err} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_ctrl: got f_v/o_v/i_r/o_err=%b want 0000", {f_v, o_v, i_r, o_err});
    end
    n_total++;
    if (f_d !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_f_d: got %h want 00", f_d);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    n_total++;
    if (i_r !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_i_r_before_edge: got %b want 0", i_r);
    end
    @(negedge clk);
    tick();
    n_total++;
    if (i_r !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_i_r_after_edge: got %b want 1", i_r);
    end
  endtask

  task automatic test_basic();
    o_r = 1'b0;
    i_v = 1'b1; i_d = 8'h11; i_done = 1'b0;
    tick();
    n_total++;
    if (f_v !== 1'b1 || f_d !== 8'h11) begin
      n_bad++;
      $display("FAIL basic_fb1: got f_v=%b f_d=%h want 1 11", f_v, f_d);
    end
    i_d = 8'h12;
    tick();
    n_total++;
    if (f_v !== 1'b1 || f_d !== 8'h12) begin
      n_bad++;
      $display("FAIL basic_fb2: got f_v=%b f_d=%h want 1 12", f_v, f_d);
    end
    i_d = 8'h13; i_done = 1'b1;
    tick();
    i_v = 1'b0; i_done = 1'b0;
    n_total++;
    if (f_v !== 1'b0 || f_d !== 8'h12) begin
      n_bad++;
      $display("FAIL basic_no_fb: got f_v=%b f_d=%h want 0 12", f_v, f_d);
    end
    n_total++;
    if (o_v !== 1'b1 || o_d !== 8'h13 || o_cnt !== 3'd3 || o_err !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_exit: got v=%b d=%h cnt=%0d err=%b want 1 13 3 0",
               o_v, o_d, o_cnt, o_err);
    end
    o_r = 1'b1;
    tick();
    o_r = 1'b0;
    n_total++;
    if (o_v !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_drain: got o_v=%b want 0", o_v);
    end
  endtask

  task automatic test_backpressure();
    o_r = 1'b0;
    i_v = 1'b1; i_done = 1'b1; i_d = 8'hA0;
    tick();
    i_d = 8'hA1;
    tick();
    n_total++;
    if (i_r !== 1'b0 || o_d !== 8'hA0) begin
      n_bad++;
      $display("FAIL bp_full: got i_r=%b o_d=%h want 0 a0", i_r, o_d);
    end
    i_d = 8'hA2;
    tick();
    n_total++;
    if (i_r !== 1'b0 || o_v !== 1'b1 || o_d !== 8'hA0) begin
      n_bad++;
      $display("FAIL bp_stall: got i_r=%b o_v=%b o_d=%h want 0 1 a0", i_r, o_v, o_d);
    end
    o_r = 1'b1;
    tick();
    n_total++;
    if (i_r !== 1'b1 || o_d !== 8'hA1) begin
      n_bad++;
      $display("FAIL bp_pop_no_bypass: got i_r=%b o_d=%h want 1 a1", i_r, o_d);
    end
    tick();
    n_total++;
    if (o_v !== 1'b1 || o_d !== 8'hA2 || o_cnt !== 3'd1) begin
      n_bad++;
      $display("FAIL bp_push_pop: got o_v=%b o_d=%h cnt=%0d want 1 a2 1", o_v, o_d, o_cnt);
    end
    i_v = 1'b0; i_done = 1'b0;
    tick();
    o_r = 1'b0;
    n_total++;
    if (o_v !== 1'b0 || i_r !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_empty: got o_v=%b i_r=%b want 0 1", o_v, i_r);
    end
  endtask

`ifdef BASE_ASMX_ITER_LIMIT_EN
  task automatic test_limit();
    o_r = 1'b0;
    i_v = 1'b1; i_done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      i_d = 8'(8'h40 + k);
      tick();
      if (k < 3) begin
        n_total++;
        if (f_v !== 1'b1 || f_d !== 8'(8'h40 + k)) begin
          n_bad++;
          $display("FAIL limit_fb%0d: got f_v=%b f_d=%h want 1 %h", k, f_v, f_d, 8'(8'h40 + k));
        end
      end
    end
    i_v = 1'b0;
    n_total++;
    if (f_v !== 1'b0 || o_v !== 1'b1 || o_cnt !== 3'd4 || o_err !== 1'b1 || o_d !== 8'h43) begin
      n_bad++;
      $display("FAIL limit_exit: got f_v=%b o_v=%b d=%h cnt=%0d err=%b want 0 1 43 4 1",
               f_v, o_v, o_d, o_cnt, o_err);
    end
    o_r = 1'b1;
    tick();
    o_r = 1'b0;
  endtask
`else
  task automatic test_saturate();
    o_r = 1'b0;
    i_v = 1'b1; i_done = 1'b0;
    for (int k = 0; k < 10; k++) begin
      i_d = 8'($urandom);
      tick();
    end
    i_d = 8'h5A; i_done = 1'b1;
    tick();
    i_v = 1'b0; i_done = 1'b0;
    n_total++;
    if (o_v !== 1'b1 || o_d !== 8'h5A || o_cnt !== 3'd7 || o_err !== 1'b0) begin
      n_bad++;
      $display("FAIL sat_exit: got v=%b d=%h cnt=%0d err=%b want 1 5a 7 0",
               o_v, o_d, o_cnt, o_err);
    end
    o_r = 1'b1;
    tick();
    o_r = 1'b0;
  endtask
`endif

  task automatic test_reset_mid();
    o_r = 1'b0;
    i_v = 1'b1; i_done = 1'b1; i_d = 8'h77;
    tick();
    i_done = 1'b0; i_d = 8'h78;
    tick();
    i_v = 1'b0;
    n_total++;
    if (f_v !== 1'b1 || o_v !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_setup: got f_v=%b o_v=%b want 1 1", f_v, o_v);
    end
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    n_total++;
    if (o_v !== 1'b0 || f_v !== 1'b0 || i_r !== 1'b0 || f_d !== 8'h00) begin
      n_bad++;
      $display("FAIL mid_async: got o_v=%b f_v=%b i_r=%b f_d=%h want 0 0 0 00",
               o_v, f_v, i_r, f_d);
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    i_v = 1'b1; i_done = 1'b1; i_d = 8'h79;
    tick();
    i_v = 1'b0; i_done = 1'b0;
    n_total++;
    if (o_v !== 1'b1 || o_d !== 8'h79 || o_cnt !== 3'd1) begin
      n_bad++;
      $display("FAIL mid_after: got o_v=%b o_d=%h cnt=%0d want 1 79 1", o_v, o_d, o_cnt);
    end
    o_r = 1'b1;
    tick();
    o_r = 1'b0;
  endtask

  task automatic test_random();
    bit exp_ir;
    bit exp_ov;
    for (int c = 0; c < 400; c++) begin
      exp_ir = m_rdy && (m_q.size() < 2);
      exp_ov = (m_q.size() > 0);
      n_total++;
      if (i_r !== exp_ir) begin
        n_bad++;
        $display("FAIL rnd_i_r c=%0d: got %b want %b", c, i_r, exp_ir);
      end
      n_total++;
      if (o_v !== exp_ov) begin
        n_bad++;
        $display("FAIL rnd_o_v c=%0d: got %b want %b", c, o_v, exp_ov);
      end
      n_total++;
      if (f_v !== m_fv || f_d !== m_fd) begin
        n_bad++;
        $display("FAIL rnd_fb c=%0d: got f_v=%b f_d=%h want %b %h", c, f_v, f_d, m_fv, m_fd);
      end
      if (exp_ov) begin
        n_total++;
        if (o_d !== m_q[0].d || int'(o_cnt) != m_q[0].cnt || o_err !== m_q[0].err) begin
          n_bad++;
          $display("FAIL rnd_head c=%0d: got d=%h cnt=%0d err=%b want %h %0d %b",
                   c, o_d, o_cnt, o_err, m_q[0].d, m_q[0].cnt, m_q[0].err);
        end
      end
      i_v    = ($urandom_range(0, 3) != 0);
      i_done = ($urandom_range(0, 4) == 0);
      i_d    = 8'($urandom);
      o_r    = ($urandom_range(0, 2) != 0);
      tick();
    end
    i_v = 1'b0; i_done = 1'b0; o_r = 1'b0;
  endtask

  initial begin
    reset_n = 1'b1;
    i_v = 1'b0; i_d = '0; i_done = 1'b0; o_r = 1'b0;
    model_reset();
    test_reset();
    test_basic();
    test_backpressure();
`ifdef BASE_ASMX_ITER_LIMIT_EN
    test_limit();
`else
    test_saturate();
`endif
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
